// File: rtl/chien_consts_pkg.sv
// Shared constants and types for the Chien-search position collector.
// The optional dedup feature is selected by the CHIEN_COLLECT_DEDUP_EN macro.
package chien_consts_pkg;

    localparam int W        = 10;
    localparam int T        = 11;
    localparam int P        = 32;
    localparam int N        = 1023;
    localparam int CODE_LEN = 544;

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(T + 1);
    localparam int LW = $clog2(P + 1);

    typedef logic [PW-1:0] pos_t;

    localparam pos_t POS_LIMIT = pos_t'(CODE_LEN);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DRAIN} collect_state_e;

endpackage

// File: rtl/chien_hit_prefix.sv
// Per-lane qualification, exclusive prefix count and popcount of a Chien hit vector.
// With CHIEN_COLLECT_DEDUP_EN defined, positions already stored or repeated by a lower lane are killed.
module chien_hit_prefix
    import chien_consts_pkg::*;
(
`ifdef CHIEN_COLLECT_DEDUP_EN
    input  pos_t                 list [T],
    input  logic [CW-1:0]        cnt,
`endif
    input  logic [P-1:0]         hit_mask,
    input  pos_t [P-1:0]         pos_bus,
    output logic [P-1:0]         qual,
    output logic [P-1:0][LW-1:0] prefix,
    output logic [LW-1:0]        total
);

    logic [P-1:0]  in_range;
    logic [LW-1:0] acc;

    always_comb begin
        in_range = '0;
        for (int t = 0; t < P; t++) begin
            in_range[t] = hit_mask[t] && (pos_bus[t] < POS_LIMIT);
        end
    end

`ifdef CHIEN_COLLECT_DEDUP_EN
    logic [P-1:0] kill;

    // A lane dies if its position is already in the list or on any lower qualified lane.
    always_comb begin
        kill = '0;
        for (int t = 0; t < P; t++) begin
            for (int j = 0; j < T; j++) begin
                if ((j < int'(cnt)) && (list[j] == pos_bus[t])) kill[t] = 1'b1;
            end
            for (int u = 0; u < t; u++) begin
                if (in_range[u] && (pos_bus[u] == pos_bus[t])) kill[t] = 1'b1;
            end
        end
    end

    assign qual = in_range & ~kill;
`else
    assign qual = in_range;
`endif

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int t = 0; t < P; t++) begin
            prefix[t] = acc;
            acc       = acc + LW'(qual[t]);
        end
        total = acc;
    end

endmodule

// File: rtl/chien_pos_collector.sv
// Collects up to T Chien error positions per codeword, checks the count against deg(sigma)
// and drains them as a valid/ready stream. Build with CHIEN_COLLECT_DEDUP_EN to drop duplicates.
module chien_pos_collector
    import chien_consts_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [3:0]   sigma_deg_i,
    input  logic [P-1:0] hit_mask_i,
    input  pos_t [P-1:0] pos_bus_i,
    input  logic         chien_done_i,
    output logic         busy_o,
    output logic         result_valid_o,
    output logic [3:0]   err_cnt_o,
    output logic         fail_o,
    output logic         pos_valid_o,
    input  logic         pos_ready_i,
    output pos_t         pos_o,
    output logic         pos_last_o
);

    collect_state_e state, state_nxt;

    logic [CW-1:0]         cnt, cnt_nxt, deg_q, rd_idx;
    logic                  overflow, ovf_nxt, fail_nxt;
    pos_t                  list [T];
    pos_t                  wdata [T];
    logic [T-1:0]          wen;
    logic [P-1:0]          qual;
    logic [P-1:0][LW-1:0]  prefix;
    logic [LW-1:0]         total;
    logic [LW:0]           sum;
    logic                  capture, verdict_load, drain_load, xfer;

    chien_hit_prefix u_prefix (
`ifdef CHIEN_COLLECT_DEDUP_EN
        .list     (list),
        .cnt      (cnt),
`endif
        .hit_mask (hit_mask_i),
        .pos_bus  (pos_bus_i),
        .qual     (qual),
        .prefix   (prefix),
        .total    (total)
    );

    // Appends saturate at T; anything beyond is dropped but remembered as overflow.
    always_comb begin
        sum      = (LW+1)'(cnt) + (LW+1)'(total);
        ovf_nxt  = overflow | (sum > (LW+1)'(T));
        cnt_nxt  = (sum > (LW+1)'(T)) ? CW'(T) : sum[CW-1:0];
        fail_nxt = ovf_nxt | (cnt_nxt != deg_q);
    end

    always_comb begin
        for (int j = 0; j < T; j++) begin
            wen[j]   = 1'b0;
            wdata[j] = '0;
            for (int t = 0; t < P; t++) begin
                if (qual[t] && ((int'(cnt) + int'(prefix[t])) == j)) begin
                    wen[j]   = 1'b1;
                    wdata[j] = pos_bus_i[t];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (chien_done_i) state_nxt = CHECK;
                CHECK:   state_nxt = (fail_o || (cnt == '0)) ? IDLE : DRAIN;
                DRAIN:   if (pos_valid_o && pos_ready_i && pos_last_o) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // A start in any state pre-empts the current codeword, so every strobe is gated by it.
    always_comb begin
        capture        = 1'b0;
        verdict_load   = 1'b0;
        drain_load     = 1'b0;
        xfer           = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = (state != IDLE);
        case (state)
            COLLECT: begin
                capture      = !start_i;
                verdict_load = !start_i && chien_done_i;
            end
            CHECK: begin
                result_valid_o = !start_i;
                drain_load     = !start_i && !fail_o && (cnt != '0);
            end
            DRAIN:   xfer = !start_i && pos_valid_o && pos_ready_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int j = 0; j < T; j++) begin
                if (wen[j]) list[j] <= wdata[j];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= '0;
            overflow    <= 1'b0;
            deg_q       <= '0;
            err_cnt_o   <= '0;
            fail_o      <= 1'b0;
            pos_valid_o <= 1'b0;
            pos_last_o  <= 1'b0;
            pos_o       <= '0;
            rd_idx      <= '0;
        end else if (start_i) begin
            cnt         <= '0;
            overflow    <= 1'b0;
            deg_q       <= sigma_deg_i;
            err_cnt_o   <= '0;
            fail_o      <= 1'b0;
            pos_valid_o <= 1'b0;
            pos_last_o  <= 1'b0;
            rd_idx      <= '0;
        end else begin
            if (capture) begin
                cnt      <= cnt_nxt;
                overflow <= ovf_nxt;
            end
            if (verdict_load) begin
                err_cnt_o <= cnt_nxt;
                fail_o    <= fail_nxt;
            end
            if (drain_load) begin
                pos_valid_o <= 1'b1;
                pos_o       <= list[0];
                pos_last_o  <= (cnt == CW'(1));
                rd_idx      <= CW'(1);
            end else if (xfer) begin
                if (pos_last_o) begin
                    pos_valid_o <= 1'b0;
                    pos_last_o  <= 1'b0;
                end else begin
                    pos_o      <= list[rd_idx];
                    pos_last_o <= (rd_idx == (cnt - CW'(1)));
                    rd_idx     <= rd_idx + CW'(1);
                end
            end
        end
    end

endmodule
